// File: rtl/clk_div_cfg_ctrl_if.sv
// Configuration handshake between the register file and the divider
// reconfiguration sequencer, plus the settings the sequencer drives
// toward the divider instances.
interface clk_div_cfg_ctrl_if;
  logic       i_cfg_valid;
  logic [7:0] i_cfg_ratio;
  logic       i_cfg_en;
  logic       o_cfg_ready;
  logic [7:0] o_div_ratio;
  logic       o_clk_en;
  logic       o_bypass;
  logic       o_busy;
  logic       o_done;

  // Requester side: the register file presents settings and watches status.
  modport master (
    output i_cfg_valid, i_cfg_ratio, i_cfg_en,
    input  o_cfg_ready, o_div_ratio, o_clk_en, o_bypass, o_busy, o_done
  );

  // Sequencer side: takes requests and drives the divider controls.
  modport slave (
    input  i_cfg_valid, i_cfg_ratio, i_cfg_en,
    output o_cfg_ready, o_div_ratio, o_clk_en, o_bypass, o_busy, o_done
  );
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// Reconfiguration sequencer for the integer clock divider.
// A new ratio is only written while the divider enable is low: a running
// divider is gated first and left to drain, the ratio is loaded, and the
// enable is restored after a settle interval.
module clk_div_cfg_ctrl #(
  parameter int unsigned DRAIN_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [7:0]  RST_RATIO  = 8'd1
) (
  input logic               i_clk,
  input logic               i_rst,
  clk_div_cfg_ctrl_if.slave cfg
);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    LOAD,
    SETTLE
  } state_t;

  localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] pend_ratio;
  logic       pend_en;
  logic [7:0] div_ratio;
  logic       clk_en;
  logic       done;
  logic       noop_seen;
  logic       ready;
  logic       accept;
  logic       is_noop;

  // Ready is a decode of the registered state, held low while in reset.
  assign ready   = (state == IDLE) && !i_rst;
  assign accept  = cfg.i_cfg_valid && ready;
  assign is_noop = (cfg.i_cfg_ratio == div_ratio) && (cfg.i_cfg_en == clk_en);

  assign cfg.o_cfg_ready = ready;
  assign cfg.o_div_ratio = div_ratio;
  assign cfg.o_clk_en    = clk_en;
  assign cfg.o_bypass    = (div_ratio < 8'd2);
  assign cfg.o_busy      = (state != IDLE);
  assign cfg.o_done      = done;

  // Sequencer FSM: gate, drain, load the ratio, settle, then restore enable.
  // A no-op request is reported one edge after acceptance so that every
  // completion is counted on the same edge-latency basis.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      pend_ratio <= 8'd0;
      pend_en    <= 1'b0;
      div_ratio  <= RST_RATIO;
      clk_en     <= 1'b0;
      done       <= 1'b0;
      noop_seen  <= 1'b0;
    end else begin
      done      <= noop_seen;
      noop_seen <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pend_ratio <= cfg.i_cfg_ratio;
            pend_en    <= cfg.i_cfg_en;
            if (is_noop) begin
              noop_seen <= 1'b1;
            end else if (clk_en) begin
              clk_en <= 1'b0;
              cnt    <= 8'd0;
              state  <= GATE;
            end else begin
              state <= LOAD;
            end
          end
        end
        GATE: begin
          if (cnt == DRAIN_LAST) begin
            state <= LOAD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        LOAD: begin
          div_ratio <= pend_ratio;
          cnt       <= 8'd0;
          state     <= SETTLE;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            clk_en <= pend_en;
            done   <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
